peri_timer_slave: RTL and testbench

- Memory-mapped timer peripheral; the responder end of the one-stage peripheral bus, occupying one `NUM_PERI` slot.
- Accepts single-cycle wren/rden strobes with address, data and byte strobes from the bus.
- Returns a one-cycle valid pulse with read data.
- Provides a prescaled 32-bit up-counter, a compare match flag and a level interrupt to the core.

---
 rtl/peri_timer_slave_pkg.sv | 40 ++++
 rtl/peri_timer_slave_if.sv | 26 ++
 rtl/peri_timer_slave_prescaler.sv | 42 ++++
 rtl/peri_timer_slave.sv | 149 ++++++++++++++
 tb/tb_peri_timer_slave.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/peri_timer_slave_pkg.sv
// peri_timer_slave_pkg
// Shared constants for the memory-mapped timer peripheral:
//   - the bus slot defines for the timer, alongside the other peripheral slots
//   - register word offsets (addr[7:2]) and CTRL bit positions
//   - the packed CTRL register layout
`ifndef BASE_ADDR_TIMER
`define BASE_ADDR_TIMER 32'h4003_0000
`endif
`ifndef TIMER
`define TIMER 3
`endif

package peri_timer_slave_pkg;

  // Register word offsets as seen on addr[7:2] (byte offset = value * 4).
  localparam logic [5:0] TMR_CTRL  = 6'h00;  // 0x00
  localparam logic [5:0] TMR_PRESC = 6'h01;  // 0x04
  localparam logic [5:0] TMR_COUNT = 6'h02;  // 0x08
  localparam logic [5:0] TMR_CMP   = 6'h03;  // 0x0C
  localparam logic [5:0] TMR_STAT  = 6'h04;  // 0x10
  localparam logic [5:0] TMR_ID    = 6'h05;  // 0x14

  // CTRL bit positions.
  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  // Packed so that {29'b0, ctrl} is the CTRL read value directly.
  typedef struct packed {
    logic auto_reload;
    logic irq_en;
    logic en;
  } ctrl_t;

  // An all-zero strobe means a full-word write.
  function automatic logic [3:0] eff_strb(input logic [3:0] strb);
    return (strb == 4'b0000) ? 4'b1111 : strb;
  endfunction

endpackage

// File: rtl/peri_timer_slave_if.sv
// peri_timer_slave_if
// One-stage peripheral bus between the bus master and a single responder slot.
//   wren / rden      : single-cycle request strobes
//   addr_32b         : byte address
//   din_32b / wstrb  : write data and byte-lane enables
//   dout_32b_valid   : one-cycle response pulse, one cycle after the strobe
//   dout_32b         : read data, meaningful while dout_32b_valid is high
interface peri_timer_slave_if;
  logic        wren;
  logic        rden;
  logic [31:0] addr_32b;
  logic [31:0] din_32b;
  logic [3:0]  wstrb;
  logic        dout_32b_valid;
  logic [31:0] dout_32b;

  modport master (
    output wren, rden, addr_32b, din_32b, wstrb,
    input  dout_32b_valid, dout_32b
  );

  modport slave (
    input  wren, rden, addr_32b, din_32b, wstrb,
    output dout_32b_valid, dout_32b
  );
endinterface

// File: rtl/peri_timer_slave_prescaler.sv
// timer_prescaler
// Divides the clock by (presc_i + 1) while enabled.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   en_i           : enable; when low the prescale count is held at 0
//   presc_i        : divide value, tick every presc_i+1 enabled cycles
//   tick_o         : combinational, high in the cycle the count equals presc_i
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;

  // Equality only: if presc_i is lowered below the running count, the count
  // runs on to its natural wrap before ticking again.
  assign tick_o = en_i && (pre_cnt_q == presc_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!en_i) begin
      pre_cnt_d = '0;
    end else if (tick_o) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/peri_timer_slave.sv
// peri_timer_slave
// Memory-mapped timer on the peripheral bus: prescaled 32-bit up-counter,
// compare match flag (write-1-to-clear) and a level interrupt.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus            : peripheral bus, slave side (strobes in, valid/data out)
//   irq_o          : registered MATCH & IRQ_EN
module peri_timer_slave
  import peri_timer_slave_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h544D_0001,
  parameter int          PRESC_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  peri_timer_slave_if.slave    bus,
  output logic                 irq_o
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;
  logic               irq_q;
  logic               valid_q;
  logic [31:0]        dout_q;

  logic               tick;
  logic [5:0]         reg_idx;
  logic [3:0]         strb;
  logic [31:0]        wmask;
  logic [31:0]        rdata;
  logic               unused_addr_bits;

  assign reg_idx          = bus.addr_32b[7:2];
  assign strb             = eff_strb(bus.wstrb);
  // Upper address bits are matched by the bus; byte offset is word aligned.
  assign unused_addr_bits = ^{bus.addr_32b[31:8], bus.addr_32b[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign wmask[gi*8 +: 8] = {8{strb[gi]}};
    end
  endgenerate

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (ctrl_q.en),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  // Read mux works on current register state, so a read sees values from
  // before any write landing in the same cycle.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      TMR_CTRL:  rdata = {29'b0, ctrl_q};
      TMR_PRESC: rdata = 32'(presc_q);
      TMR_COUNT: rdata = count_q;
      TMR_CMP:   rdata = cmp_q;
      TMR_STAT:  rdata = {31'b0, match_q};
      TMR_ID:    rdata = ID_VALUE;
      default:   rdata = '0;
    endcase
  end

  // Ordering sets the precedence of simultaneous events:
  //   W1C before the tick so a match set in the same cycle survives;
  //   register writes after the tick so software COUNT/CTRL writes win.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    if (bus.wren && (reg_idx == TMR_STAT) && strb[0] && bus.din_32b[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (ctrl_q.auto_reload) begin
          count_d = '0;
        end else begin
          ctrl_d.en = 1'b0;  // one-shot: stop and hold COUNT
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (bus.wren) begin
      case (reg_idx)
        TMR_CTRL: begin
          if (strb[0]) begin
            ctrl_d.en          = bus.din_32b[CTRL_EN];
            ctrl_d.irq_en      = bus.din_32b[CTRL_IRQ_EN];
            ctrl_d.auto_reload = bus.din_32b[CTRL_AUTO_RELOAD];
          end
        end
        TMR_PRESC: begin
          for (int i = 0; i < PRESC_W; i++) begin
            if (wmask[i]) presc_d[i] = bus.din_32b[i];
          end
        end
        TMR_COUNT: count_d = (count_d & ~wmask) | (bus.din_32b & wmask);
        TMR_CMP:   cmp_d   = (cmp_q & ~wmask) | (bus.din_32b & wmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= match_q & ctrl_q.irq_en;
      valid_q <= bus.wren | bus.rden;
      // Data holds between responses; writes (including write+read) return 0.
      if (bus.wren | bus.rden) begin
        dout_q <= bus.wren ? 32'd0 : rdata;
      end
    end
  end

  assign bus.dout_32b_valid = valid_q;
  assign bus.dout_32b       = dout_q;
  assign irq_o              = irq_q;

endmodule

// File: tb/tb_peri_timer_slave.sv
// tb_peri_timer_slave
// Directed bench for peri_timer_slave. Each bus transaction takes exactly one
// clock: inputs are driven on the falling edge, the response is checked 1 ns
// after the following rising edge, and strobes drop right after.
module tb_peri_timer_slave;

  logic clk;
  logic rst_n;
  logic irq;
  int   errors;
  int   checks;
  int   n;

  peri_timer_slave_if bus_if ();

  peri_timer_slave #(
    .ID_VALUE (32'h544D_0001),
    .PRESC_W  (16)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if.slave),
    .irq_o   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic wr, input logic rd, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_if.wren     = wr;
    bus_if.rden     = rd;
    bus_if.addr_32b = {24'h0, addr};
    bus_if.din_32b  = data;
    bus_if.wstrb    = strb;
    @(posedge clk);
    #1;
    chk({tag, " valid"}, {31'b0, bus_if.dout_32b_valid}, 32'd1);
    chk({tag, " dout"}, bus_if.dout_32b, exp);
    $display("xact %-14s wr=%0b rd=%0b addr=%02h din=%08h strb=%04b dout=%08h",
             tag, wr, rd, addr, data, strb, bus_if.dout_32b);
    bus_if.wren = 1'b0;
    bus_if.rden = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input string tag);
    xact(1'b1, 1'b0, addr, data, strb, 32'd0, tag);
  endtask

  task automatic rd_reg(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    xact(1'b0, 1'b1, addr, 32'd0, 4'b0000, exp, tag);
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b0;
    bus_if.wren     = 1'b0;
    bus_if.rden     = 1'b0;
    bus_if.addr_32b = '0;
    bus_if.din_32b  = '0;
    bus_if.wstrb    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", {31'b0, bus_if.dout_32b_valid}, 32'd0);
    chk("rst dout", bus_if.dout_32b, 32'd0);
    chk("rst irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ID, unmapped offset, CTRL reset value; valid lasts one cycle only
    rd_reg(8'h14, 32'h544D_0001, "rd ID");
    rd_reg(8'h3C, 32'h0000_0000, "rd 0x3C");
    rd_reg(8'h00, 32'h0000_0000, "rd CTRL rst");
    @(posedge clk);
    #1;
    chk("valid one cycle", {31'b0, bus_if.dout_32b_valid}, 32'd0);

    // Auto-reload: PRESC=3 -> tick every 4 cycles; 6th tick matches at CMP=5
    // 24 cycles after the enabling write, irq one cycle later.
    wr_reg(8'h04, 32'd3, 4'hF, "wr PRESC 3");
    rd_reg(8'h04, 32'd3, "rd PRESC");
    wr_reg(8'h0C, 32'd5, 4'hF, "wr CMP 5");
    wr_reg(8'h00, 32'h7, 4'hF, "wr CTRL 7");
    n = 0;
    while (irq !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq latency", n, 32'd25);
    rd_reg(8'h08, 32'd0, "rd COUNT rld");
    rd_reg(8'h10, 32'd1, "rd STAT match");
    wr_reg(8'h10, 32'd1, 4'hF, "w1c STAT");
    chk("irq lag w1c", {31'b0, irq}, 32'd1);
    @(posedge clk);
    #1;
    chk("irq fell", {31'b0, irq}, 32'd0);
    wr_reg(8'h00, 32'h0, 4'hF, "wr CTRL 0");
    rd_reg(8'h10, 32'd0, "rd STAT clr");

    // One-shot with W1C colliding with the match set
    wr_reg(8'h04, 32'd0, 4'hF, "wr PRESC 0");
    wr_reg(8'h0C, 32'd2, 4'hF, "wr CMP 2");
    wr_reg(8'h08, 32'd0, 4'hF, "wr COUNT 0");
    wr_reg(8'h00, 32'h3, 4'hF, "wr CTRL 3");
    rd_reg(8'h08, 32'd0, "rd COUNT t0");
    rd_reg(8'h08, 32'd1, "rd COUNT t1");
    wr_reg(8'h10, 32'd1, 4'hF, "w1c at match");
    rd_reg(8'h10, 32'd1, "rd STAT kept");
    chk("irq one-shot", {31'b0, irq}, 32'd1);
    rd_reg(8'h00, 32'h2, "rd CTRL oneshot");
    rd_reg(8'h08, 32'd2, "rd COUNT held");
    wr_reg(8'h10, 32'd1, 4'h1, "w1c idle");
    chk("irq lag w1c2", {31'b0, irq}, 32'd1);
    @(posedge clk);
    #1;
    chk("irq fell2", {31'b0, irq}, 32'd0);
    rd_reg(8'h10, 32'd0, "rd STAT clr2");

    // Byte lanes
    wr_reg(8'h08, 32'h1122_3344, 4'hF, "wr COUNT full");
    wr_reg(8'h08, 32'hAABB_CCDD, 4'b0010, "wr COUNT lane1");
    rd_reg(8'h08, 32'h1122_CC44, "rd COUNT lanes");
    wr_reg(8'h0C, 32'h1234_5678, 4'b0000, "wr CMP strb0");
    rd_reg(8'h0C, 32'h1234_5678, "rd CMP strb0");
    wr_reg(8'h00, 32'h7, 4'b1110, "wr CTRL nolane0");
    rd_reg(8'h00, 32'h2, "rd CTRL unchanged");

    // COUNT write in a tick cycle wins; CTRL EN clear in a tick cycle still counts
    wr_reg(8'h00, 32'h0, 4'hF, "wr CTRL 0 b");
    wr_reg(8'h0C, 32'hFFFF_FFF0, 4'hF, "wr CMP big");
    wr_reg(8'h08, 32'h100, 4'hF, "wr COUNT 100");
    wr_reg(8'h00, 32'h5, 4'hF, "wr CTRL 5");
    wr_reg(8'h08, 32'h50, 4'hF, "wr COUNT tick");
    rd_reg(8'h08, 32'h50, "rd COUNT wins");
    wr_reg(8'h00, 32'h0, 4'hF, "wr CTRL off tick");
    rd_reg(8'h08, 32'h52, "rd COUNT last");

    // Wrap 0xFFFF_FFFF -> 0 without a match
    wr_reg(8'h08, 32'hFFFF_FFFF, 4'hF, "wr COUNT max");
    wr_reg(8'h0C, 32'd5, 4'hF, "wr CMP 5 b");
    wr_reg(8'h00, 32'h5, 4'hF, "wr CTRL 5 b");
    rd_reg(8'h08, 32'hFFFF_FFFF, "rd COUNT max");
    rd_reg(8'h08, 32'd0, "rd COUNT wrap");
    rd_reg(8'h10, 32'd0, "rd STAT nowrap");
    wr_reg(8'h00, 32'h0, 4'hF, "wr CTRL 0 c");
    rd_reg(8'h08, 32'd3, "rd COUNT stop");

    // Write and read together: write happens, response data is 0
    xact(1'b1, 1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF, 32'd0, "wr+rd CMP");
    rd_reg(8'h0C, 32'hCAFE_F00D, "rd CMP after");

    // Back-to-back reads, then data holds after valid drops
    rd_reg(8'h14, 32'h544D_0001, "b2b ID");
    rd_reg(8'h0C, 32'hCAFE_F00D, "b2b CMP");
    rd_reg(8'h08, 32'd3, "b2b COUNT");
    @(posedge clk);
    #1;
    chk("b2b valid end", {31'b0, bus_if.dout_32b_valid}, 32'd0);
    chk("dout holds", bus_if.dout_32b, 32'd3);

    // Reset with a response pending
    @(negedge clk);
    bus_if.rden     = 1'b1;
    bus_if.addr_32b = 32'h14;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst pend valid", {31'b0, bus_if.dout_32b_valid}, 32'd0);
    chk("rst pend dout", bus_if.dout_32b, 32'd0);
    bus_if.rden = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no resp after rst", {31'b0, bus_if.dout_32b_valid}, 32'd0);
    end
    rd_reg(8'h0C, 32'd0, "rd CMP rst");
    rd_reg(8'h00, 32'd0, "rd CTRL rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
